// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch master: widths, reset PC
// and the tag that travels alongside each outstanding RAM read.
package fetch_pkg;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 32;
  localparam int READ_LATENCY = 1;
  localparam int FIFO_DEPTH   = 4;
  localparam int EPOCH_W      = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  pc;
    logic [EPOCH_W-1:0] epoch;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {data, pc} entries; flush empties it
// in one cycle and takes priority over a same-cycle push or pop.
module fetch_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head reads as zero while empty so stale entries never leak onto the bus.
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_master.sv
// Avalon-MM read master streaming sequential instruction words from on-chip RAM
// into a small buffer, with credit-based issue and epoch-tagged redirect flush.
module inst_fetch_master #(
  parameter int                            ADDR_W       = fetch_pkg::ADDR_W,
  parameter int                            DATA_W       = fetch_pkg::DATA_W,
  parameter int                            READ_LATENCY = fetch_pkg::READ_LATENCY,
  parameter int                            FIFO_DEPTH   = fetch_pkg::FIFO_DEPTH,
  parameter logic [fetch_pkg::ADDR_W-1:0]  RESET_PC     = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int FW    = DATA_W + ADDR_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  fetch_tag_t         tag_q [READ_LATENCY];
  fetch_tag_t         tag_d [READ_LATENCY];

  fetch_tag_t         ret_tag;
  logic [CNT_W:0]     credit_used;
  logic               issue, push, pop;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_head;

  always_comb begin
    ret_tag     = tag_q[READ_LATENCY-1];
    // Buffered plus outstanding reads must fit in the FIFO, so a return always has room.
    credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    issue       = enable & ~redirect_valid & ~reset &
                  (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    push        = ret_tag.valid & (ret_tag.epoch == epoch_q);
    pop         = ~fifo_empty & instr_ready & ~redirect_valid;

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    epoch_d    = epoch_q + EPOCH_W'(redirect_valid);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret_tag.valid);

    tag_d[0] = '{valid: issue, pc: fetch_pc_q, epoch: epoch_q};
    for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      epoch_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      epoch_q    <= epoch_d;
      tag_q      <= tag_d;
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({avm_readdata, ret_tag.pc}),
    .pop       (pop),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  assign instr_valid    = ~fifo_empty;
  assign instr_data     = fifo_head[FW-1:ADDR_W];
  assign instr_pc       = fifo_head[ADDR_W-1:0];
  assign avm_address    = fetch_pc_q;
  assign avm_chipselect = issue;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_inst_fetch_master.sv
// Directed bench for inst_fetch_master with a 1-cycle-latency RAM model.
module tb_inst_fetch_master;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata = '0;

  always #5 clk = ~clk;

  inst_fetch_master #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (1),
    .FIFO_DEPTH   (4),
    .RESET_PC     (13'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata)
  );

  function automatic logic [31:0] ram_word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h1111_1111) ^ 32'h5A00_0000;
  endfunction

  always @(posedge clk) begin
    if (avm_chipselect) avm_readdata <= ram_word(avm_address);
  end

  int                n_cmp = 0;
  int                n_err = 0;
  int                n_acc;
  int                n_cs;
  logic [ADDR_W-1:0] exp_pc;
  logic [ADDR_W-1:0] first_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic accept_check();
    if (instr_valid && instr_ready && !redirect_valid && !reset) begin
      check("acc_pc", 32'(instr_pc), 32'(exp_pc));
      check("acc_data", instr_data, ram_word(exp_pc));
      exp_pc = exp_pc + 13'd1;
      n_acc++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      check("rst_cs", 32'(avm_chipselect), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_addr", 32'(avm_address), 32'd0);
    end
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("tie_write", 32'(avm_write), 32'd0);
    check("tie_be", 32'(avm_byteenable), 32'hF);
    check("tie_clken", 32'(avm_clken), 32'd1);

    // Streaming from pc 0 with ready held high.
    reset = 1'b0;
    #1;
    check("s_c0_cs", 32'(avm_chipselect), 32'd1);
    check("s_c0_addr", 32'(avm_address), 32'd0);
    check("s_c0_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    #1;
    check("s_c1_cs", 32'(avm_chipselect), 32'd1);
    check("s_c1_addr", 32'(avm_address), 32'd1);
    check("s_c1_valid", 32'(instr_valid), 32'd0);
    for (int k = 2; k < 10; k++) begin
      next_cycle();
      #1;
      check("s_valid", 32'(instr_valid), 32'd1);
      check("s_pc", 32'(instr_pc), 32'(k - 2));
      check("s_data", instr_data, ram_word(ADDR_W'(k - 2)));
      check("s_cs", 32'(avm_chipselect), 32'd1);
      check("s_addr", 32'(avm_address), 32'(k));
    end

    // Backpressure: credits cap issue at four reads.
    instr_ready = 1'b0;
    do_reset();
    n_cs = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (avm_chipselect) n_cs++;
      next_cycle();
    end
    #1;
    check("bp_cs_count", 32'(n_cs), 32'd4);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_hold_pc", 32'(instr_pc), 32'd0);
    check("bp_hold_data", instr_data, ram_word(13'd0));
    instr_ready = 1'b1;
    exp_pc = '0;
    n_acc = 0;
    n_cs = 0;
    first_addr = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i < 4) check("drain_valid", 32'(instr_valid), 32'd1);
      accept_check();
      if (avm_chipselect) begin
        if (n_cs == 0) first_addr = avm_address;
        n_cs++;
      end
      next_cycle();
    end
    check("drain_count", 32'(n_acc), 32'd8);
    check("resume_addr", 32'(first_addr), 32'd4);

    // Redirect with three buffered words and one read returning.
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0100;
    instr_ready    = 1'b1;
    #1;
    check("rd_r_cs", 32'(avm_chipselect), 32'd0);
    check("rd_r_valid", 32'(instr_valid), 32'd1);
    check("rd_r_pc", 32'(instr_pc), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("rd_r1_valid", 32'(instr_valid), 32'd0);
    check("rd_r1_cs", 32'(avm_chipselect), 32'd1);
    check("rd_r1_addr", 32'(avm_address), 32'h0100);
    exp_pc = 13'h0100;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      accept_check();
      next_cycle();
      #1;
    end
    check("rd_acc_count", 32'(n_acc), 32'd10);

    // Enable low: no new reads, outstanding words still delivered.
    enable = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("en_cs", 32'(avm_chipselect), 32'd0);
      accept_check();
      next_cycle();
    end
    #1;
    check("en_drained", 32'(n_acc), 32'd2);
    check("en_valid", 32'(instr_valid), 32'd0);

    // Back-to-back redirects, then wrap at the top of the address space.
    enable         = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 13'h0AAA;
    #1;
    next_cycle();
    redirect_pc = 13'h1FFE;
    #1;
    check("wr_r2_cs", 32'(avm_chipselect), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("wr_cs", 32'(avm_chipselect), 32'd1);
    check("wr_addr", 32'(avm_address), 32'h1FFE);
    check("wr_valid", 32'(instr_valid), 32'd0);
    exp_pc = 13'h1FFE;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      accept_check();
      next_cycle();
      #1;
    end
    check("wr_acc_count", 32'(n_acc), 32'd6);
    check("wr_next_pc", 32'(exp_pc), 32'h0004);

    // Reset in the middle of a stream with words buffered.
    for (int i = 0; i < 4; i++) begin
      accept_check();
      next_cycle();
      #1;
    end
    instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    check("mr_cs", 32'(avm_chipselect), 32'd0);
    next_cycle();
    reset       = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("mr_valid", 32'(instr_valid), 32'd0);
    check("mr_cs_after", 32'(avm_chipselect), 32'd1);
    check("mr_addr", 32'(avm_address), 32'd0);
    exp_pc = '0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      accept_check();
      next_cycle();
      #1;
    end
    check("mr_acc_count", 32'(n_acc), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
